// File: rtl/ej32_fetch_seq_if.sv
// Fetch-sequencer bus bundle: stage enable, memory byte in, and the opcode /
// phase / program-counter outputs consumed by the load/store and ALU stages.
interface ej32_fetch_seq_if #(
    parameter int unsigned ASZ = 17
);
    logic           en;
    logic [7:0]     mem_d;
    logic [7:0]     code_o;
    logic [2:0]     phase_o;
    logic [ASZ-1:0] p_o;
    logic           fetch_o;
    logic           done_o;

    // The sequencer side.
    modport master (
        input  en,
        input  mem_d,
        output code_o,
        output phase_o,
        output p_o,
        output fetch_o,
        output done_o
    );

    // The environment side: memory and downstream stages.
    modport slave (
        output en,
        output mem_d,
        input  code_o,
        input  phase_o,
        input  p_o,
        input  fetch_o,
        input  done_o
    );
endinterface

// File: rtl/ej32_fetch_seq.sv
// eJ32 instruction fetch and phase sequencer. Owns the program counter, latches
// the opcode, and steps a per-opcode phase counter for the downstream stages.
// Handles immediate-operand advancement and 16-bit relative goto.
// ASZ must be greater than 16 (the goto offset is sign-extended into it).
module ej32_fetch_seq #(
    parameter int unsigned    ASZ  = 17,
    parameter logic [ASZ-1:0] COLD = '0
) (
    input  logic               clk,
    input  logic               rst,
    ej32_fetch_seq_if.master   bus
);

    typedef enum logic [1:0] {StCold, StFetch, StDecode, StExec} state_e;

    localparam logic [ASZ-1:0] POne = ASZ'(1);

    localparam logic [7:0] OpBipush = 8'h10;
    localparam logic [7:0] OpSipush = 8'h11;
    localparam logic [7:0] OpLdi    = 8'h12;
    localparam logic [7:0] OpGoto   = 8'ha7;

    state_e         state_q, state_d;
    logic [ASZ-1:0] p_q, p_d;
    logic [ASZ-1:0] base_q, base_d;
    logic [7:0]     code_q, code_d;
    logic [2:0]     phase_q, phase_d;
    logic [15:0]    opr_q, opr_d;
    logic           fetch_q, fetch_d;
    logic           done_q, done_d;

    logic [2:0]     last_cur;
    logic [ASZ-1:0] goto_tgt;
    logic           is_imm;

    // Last phase index of each opcode; everything not listed finishes in phase 0.
    function automatic logic [2:0] last_of(input logic [7:0] op);
        case (op)
            8'h2e, 8'h4f:               last_of = 3'd4;
            8'h35, 8'h56, 8'h84:        last_of = 3'd2;
            8'h33, 8'h54, 8'hfc, 8'hfd: last_of = 3'd1;
            OpBipush:                   last_of = 3'd1;
            OpSipush:                   last_of = 3'd2;
            OpLdi:                      last_of = 3'd3;
            OpGoto:                     last_of = 3'd2;
            default:                    last_of = 3'd0;
        endcase
    endfunction

    assign last_cur = last_of(code_q);
    assign is_imm   = (code_q == OpBipush) || (code_q == OpSipush) || (code_q == OpLdi);
    // Relative target from the opcode address, wrapping modulo 2^ASZ.
    assign goto_tgt = base_q + {{(ASZ-16){opr_q[15]}}, opr_q};

    // Next-state, next-pc and registered-output computation.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        base_d  = base_q;
        code_d  = code_q;
        phase_d = phase_q;
        opr_d   = opr_q;
        fetch_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StCold: begin
                p_d     = COLD;
                state_d = StFetch;
                fetch_d = 1'b1;
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                code_d  = bus.mem_d;
                base_d  = p_q;
                p_d     = p_q + POne;
                phase_d = 3'd0;
                opr_d   = 16'h0000;
                state_d = StExec;
                done_d  = (last_of(bus.mem_d) == 3'd0);
            end
            StExec: begin
                if (phase_q == last_cur) begin
                    phase_d = 3'd0;
                    state_d = StFetch;
                    fetch_d = 1'b1;
                    if (code_q == OpGoto) begin
                        p_d = goto_tgt;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                    done_d  = ((phase_q + 3'd1) == last_cur);
                    if (is_imm) begin
                        p_d = p_q + POne;
                    end
                    if (code_q == OpGoto) begin
                        // High offset byte comes first, then the low byte.
                        if (phase_q == 3'd0) begin
                            opr_d[15:8] = bus.mem_d;
                            p_d         = p_q + POne;
                        end else begin
                            opr_d[7:0] = bus.mem_d;
                        end
                    end
                end
            end
            default: state_d = StCold;
        endcase
    end

    // State register: reset wins, otherwise update only when the stage is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCold;
            p_q     <= COLD;
            base_q  <= '0;
            code_q  <= 8'h00;
            phase_q <= 3'd0;
            opr_q   <= 16'h0000;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.en) begin
            state_q <= state_d;
            p_q     <= p_d;
            base_q  <= base_d;
            code_q  <= code_d;
            phase_q <= phase_d;
            opr_q   <= opr_d;
            fetch_q <= fetch_d;
            done_q  <= done_d;
        end
    end

    assign bus.code_o  = code_q;
    assign bus.phase_o = phase_q;
    assign bus.p_o     = p_q;
    assign bus.fetch_o = fetch_q;
    assign bus.done_o  = done_q;

endmodule
